// File: rtl/dadda_pkg.sv
// Shared types and constants for the Dadda multiplier MAC datapath.
package dadda_pkg;

   // Output width of the 4x4 Dadda tree multiplier
   localparam int unsigned PROD_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // Bits needed to hold a beat count in the range 0..max_len
   function automatic int unsigned cnt_width(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/dadda_mac_acc_if.sv
// Product-in / frame-result-out handshake bundle for the MAC accumulate stage.
interface dadda_mac_acc_if #(
   parameter int unsigned PROD_W = 8,
   parameter int unsigned ACC_W  = 12,
   parameter int unsigned CNT_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_product;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_ovf
   );
endinterface

// File: rtl/sat_adder.sv
// Unsigned accumulate step with sticky saturation at the all-ones accumulator value.
module sat_adder #(
   parameter int unsigned PROD_W = 8,
   parameter int unsigned ACC_W  = 12
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   input  logic              ovf_in,
   output logic [ACC_W-1:0]  sum_c,
   output logic              ovf_c
);
   localparam int unsigned SUM_W = ACC_W + 1;

   logic [SUM_W-1:0] sum_w;

   always_comb begin
      sum_w = {1'b0, acc} + SUM_W'(prod);
      ovf_c = sum_w[ACC_W] | ovf_in;
      sum_c = ovf_c ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
   end
endmodule

// File: rtl/dadda_mac_acc.sv
// Frame accumulator behind the Dadda multiplier: sums product beats, presents a held frame total.
module dadda_mac_acc
   import dadda_pkg::*;
#(
   parameter int unsigned PROD_W  = PROD_W_DEF,
   parameter int unsigned ACC_W   = 12,
   parameter int unsigned MAX_LEN = 16
) (
   input logic             clk,
   input logic             rst,
   dadda_mac_acc_if.slave  bus
);
   localparam int unsigned CNT_W = cnt_width(MAX_LEN);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_acc_q, out_acc_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0] sum_c;
   logic             ovf_c;
   logic [CNT_W-1:0] count_next;
   logic             accept;

   sat_adder #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_sat_adder (
      .acc    (acc_q),
      .prod   (bus.in_product),
      .ovf_in (ovf_q),
      .sum_c  (sum_c),
      .ovf_c  (ovf_c)
   );

   assign accept     = bus.in_valid & in_ready_q;
   assign count_next = count_q + CNT_W'(1);

   // Next-state and register loads
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_acc_d   = out_acc_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;

      case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               acc_d   = sum_c;
               ovf_d   = ovf_c;
               count_d = count_next;
               // A frame closes on in_last or when the beat count hits MAX_LEN
               if (bus.in_last || (count_next == CNT_W'(MAX_LEN))) begin
                  state_d     = HOLD;
                  in_ready_d  = 1'b0;
                  out_valid_d = 1'b1;
                  out_acc_d   = sum_c;
                  out_count_d = count_next;
                  out_ovf_d   = ovf_c;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               acc_d       = '0;
               count_d     = '0;
               ovf_d       = 1'b0;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_acc_q   <= out_acc_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_count = out_count_q;
   assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_dadda_mac_acc.sv
// Self-checking bench for dadda_mac_acc: a 12-bit and a 10-bit accumulator checked against a frame-sum model.
module tb_dadda_mac_acc;

   localparam int unsigned MAXL = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [7:0] prod;
   logic       last;
   logic       ordy;
   int         sel;

   int checks = 0;
   int errors = 0;

   // Model state per DUT (0: ACC_W=12, 1: ACC_W=10)
   int m_sum   [2];
   int m_cnt   [2];
   bit m_hold  [2];
   int exp_acc [2];
   int exp_cnt [2];
   int exp_ovf [2];

   always #5 clk = ~clk;

   dadda_mac_acc_if #(.PROD_W(8), .ACC_W(12), .CNT_W(5)) b0 ();
   dadda_mac_acc_if #(.PROD_W(8), .ACC_W(10), .CNT_W(5)) b1 ();

   assign b0.in_valid   = valid && (sel == 0);
   assign b1.in_valid   = valid && (sel == 1);
   assign b0.in_product = prod;
   assign b1.in_product = prod;
   assign b0.in_last    = last;
   assign b1.in_last    = last;
   assign b0.out_ready  = ordy;
   assign b1.out_ready  = ordy;

   dadda_mac_acc #(.PROD_W(8), .ACC_W(12), .MAX_LEN(MAXL)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
   dadda_mac_acc #(.PROD_W(8), .ACC_W(10), .MAX_LEN(MAXL)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

   function automatic int acc_max(input int d);
      return (d == 0) ? 4095 : 1023;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_sum[d] = 0; m_cnt[d] = 0; m_hold[d] = 1'b0;
         exp_acc[d] = 0; exp_cnt[d] = 0; exp_ovf[d] = 0;
      end
   endtask

   task automatic check_dut(input int d);
      logic [31:0] o_v, o_r, o_a, o_c, o_o;
      if (d == 0) begin
         o_v = 32'(b0.out_valid); o_r = 32'(b0.in_ready); o_a = 32'(b0.out_acc);
         o_c = 32'(b0.out_count); o_o = 32'(b0.out_ovf);
      end else begin
         o_v = 32'(b1.out_valid); o_r = 32'(b1.in_ready); o_a = 32'(b1.out_acc);
         o_c = 32'(b1.out_count); o_o = 32'(b1.out_ovf);
      end
      chk($sformatf("dut%0d out_valid", d), o_v, 32'(m_hold[d]));
      chk($sformatf("dut%0d in_ready", d),  o_r, 32'(!m_hold[d]));
      chk($sformatf("dut%0d out_acc", d),   o_a, 32'(exp_acc[d]));
      chk($sformatf("dut%0d out_count", d), o_c, 32'(exp_cnt[d]));
      chk($sformatf("dut%0d out_ovf", d),   o_o, 32'(exp_ovf[d]));
   endtask

   // Apply the driven inputs for one clock, advance the model, check both DUTs
   task automatic step();
      for (int d = 0; d < 2; d++) begin
         if (m_hold[d]) begin
            if (ordy) m_hold[d] = 1'b0;
         end else if (valid && (sel == d)) begin
            m_sum[d] += int'(prod);
            m_cnt[d] += 1;
            if (last || (m_cnt[d] == MAXL)) begin
               exp_acc[d] = (m_sum[d] > acc_max(d)) ? acc_max(d) : m_sum[d];
               exp_ovf[d] = (m_sum[d] > acc_max(d)) ? 1 : 0;
               exp_cnt[d] = m_cnt[d];
               m_hold[d]  = 1'b1;
               m_sum[d]   = 0;
               m_cnt[d]   = 0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_dut(0);
      check_dut(1);
   endtask

   task automatic beat(input int p, input bit l);
      valid = 1'b1; prod = 8'(p); last = l;
      step();
      valid = 1'b0; last = 1'b0;
   endtask

   task automatic idle();
      valid = 1'b0; last = 1'b0; prod = 8'($urandom_range(0, 255));
      step();
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; prod = '0; last = 1'b0; ordy = 1'b1; sel = 0;
      model_reset();
      @(negedge clk);
      check_dut(0); check_dut(1);
      rst = 1'b0;
      @(negedge clk);
      check_dut(0); check_dut(1);

      // Four beats of 225, closing on in_last
      for (int i = 0; i < 4; i++) beat(225, i == 3);
      chk("t1 acc", 32'(b0.out_acc), 32'd900);
      chk("t1 count", 32'(b0.out_count), 32'd4);
      chk("t1 valid", 32'(b0.out_valid), 32'd1);
      idle();
      chk("t1 ready after handoff", 32'(b0.in_ready), 32'd1);

      // Auto-close at MAX_LEN, then the 17th beat opens a new frame
      for (int i = 1; i <= 16; i++) beat(i, 1'b0);
      chk("t2 acc", 32'(b0.out_acc), 32'd136);
      chk("t2 count", 32'(b0.out_count), 32'd16);
      idle();
      beat(5, 1'b1);
      chk("t2 next count", 32'(b0.out_count), 32'd1);
      idle();

      // Saturation on the 10-bit accumulator, cleared in the next frame
      sel = 1;
      for (int i = 0; i < 5; i++) beat(225, i == 4);
      chk("t3 sat acc", 32'(b1.out_acc), 32'd1023);
      chk("t3 sat ovf", 32'(b1.out_ovf), 32'd1);
      idle();
      beat(9, 1'b0);
      beat(9, 1'b1);
      chk("t3 clear acc", 32'(b1.out_acc), 32'd18);
      chk("t3 clear ovf", 32'(b1.out_ovf), 32'd0);
      idle();

      // Backpressure: result held, input beats ignored while pending
      sel = 0; ordy = 1'b0;
      beat(3, 1'b0);
      beat(5, 1'b1);
      for (int i = 0; i < 6; i++) beat(77, 1'b0);
      chk("t4 held acc", 32'(b0.out_acc), 32'd8);
      ordy = 1'b1;
      idle();
      beat(4, 1'b1);
      chk("t4 fresh acc", 32'(b0.out_acc), 32'd4);
      idle();

      // Asynchronous reset mid-frame discards the partial sum
      beat(100, 1'b0);
      beat(100, 1'b0);
      #2 rst = 1'b1;
      #1 model_reset();
      check_dut(0); check_dut(1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_dut(0); check_dut(1);
      beat(7, 1'b1);
      chk("t5 acc", 32'(b0.out_acc), 32'd7);
      chk("t5 count", 32'(b0.out_count), 32'd1);
      idle();

      // Gapped valid: products seen with in_valid low are ignored
      beat(10, 1'b0);
      for (int i = 0; i < 3; i++) idle();
      beat(20, 1'b0);
      beat(30, 1'b1);
      chk("t6 acc", 32'(b0.out_acc), 32'd60);
      chk("t6 count", 32'(b0.out_count), 32'd3);
      idle();

      // Randomized traffic on both accumulators
      for (int i = 0; i < 600; i++) begin
         sel   = int'($urandom_range(0, 1));
         valid = ($urandom_range(0, 3) != 0);
         prod  = 8'($urandom_range(0, 255));
         last  = ($urandom_range(0, 7) == 0);
         ordy  = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dadda_mac_acc.md
Name: dadda_mac_acc

Overview:
- Sequential accumulate stage sitting directly downstream of the 4x4 Dadda tree multiplier.
- Consumes one 8-bit product per accepted beat over a valid/ready handshake and sums a frame of products into a wider accumulator.
- Presents the frame total with a valid/ready output handshake.
- Turns the purely combinational multiplier into a dot-product / MAC datapath.

Parameters:
- PROD_W, 8: product width; matches the multiplier output p[7:0].
- ACC_W, 12: accumulator and result width; must be >= PROD_W.
- MAX_LEN, 16: maximum beats per frame; the frame auto-closes when this count is reached.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  stage can accept a beat.
- in_product  input  PROD_W  product from the multiplier, unsigned.
- in_last  input  1  marks the final beat of the frame; qualified by in_valid.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  frame sum, saturated.
- out_count  output  $clog2(MAX_LEN+1)  number of beats in the frame.
- out_ovf  output  1  sticky: frame sum exceeded 2^ACC_W-1.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, acc=0, count=0, ovf=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0. in_ready is 1 once state=IDLE.
- Reset asserted mid-frame or in HOLD discards the partial or pending result; no output beat is produced.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
- States:
  - IDLE: no beats accepted yet in this frame. in_ready=1, out_valid=0. On accept, go to ACCUM (or HOLD if the frame closes on that beat).
  - ACCUM: at least one beat accepted. in_ready=1, out_valid=0. On accept, stay in ACCUM or go to HOLD if the frame closes.
  - HOLD: result pending. in_ready=0, out_valid=1. out_acc, out_count and out_ovf are held stable until out_ready=1.
  - When out_valid && out_ready: clear acc, count and ovf; go to IDLE.
  - No input beat is accepted in the handoff cycle. This gives exactly one bubble per frame.
- Frame close: the accepted beat has in_last=1, or count+1 == MAX_LEN. Either condition alone suffices.
- Arithmetic:
  - Compute sum = acc + zero_extend(in_product) at ACC_W+1 bits.
  - If sum[ACC_W]=1 or ovf is already set: acc <= all ones, ovf <= 1. Otherwise acc <= sum[ACC_W-1:0].
  - The saturated value persists for the rest of the frame.
- Latency: on the closing accept edge, out_acc/out_count/out_ovf load the post-add values and out_valid rises. The result is visible the cycle after the last beat.
- Output registers change only on the closing accept or on reset.
- in_product and in_last are ignored when in_valid=0 or in_ready=0.
- A zero product is still a beat: it increments count.
- MAX_LEN wrap: count never exceeds MAX_LEN. The frame closes at exactly MAX_LEN beats even if in_last=0. The next beat starts a new frame.
- in_last on the MAX_LEN-th beat closes a single frame; no empty extra frame is produced.
- out_ready asserted while out_valid=0 has no effect.
- out_valid, once set, stays high until the handshake completes; no combinational path from out_ready to out_valid.

Decomposition:
- Shared package dadda_pkg holds:
  - state enum: IDLE, ACCUM, HOLD.
  - PROD_W default constant (8), tied to the 4x4 multiplier output width.
  - count-width helper function.
- Natural sub-module: sat_adder. ACC_W+1 add with sticky-saturate logic; purely combinational, reused by later MAC blocks.
- The FSM and handshake registers stay in dadda_mac_acc.

Test Plan:
1. Four beats of 225 (15*15), in_last on the 4th, out_ready=1 -> out_valid high the next cycle; out_acc=900, out_count=4, out_ovf=0; in_ready=0 for one cycle, then 1.
2. MAX_LEN=16 with in_last=0 and products 1..16 -> auto-close after the 16th beat; out_acc=136, out_count=16. The 17th beat opens a new frame with count=1.
3. ACC_W=10: five beats of 225 -> out_acc=1023, out_ovf=1. The next frame of two beats of 9 -> out_acc=18, out_ovf=0, confirming sticky flags clear per frame.
4. Backpressure: frame of 3 and 5 (last), out_ready=0 for 6 cycles -> out_valid and out_acc=8 stable, in_ready=0, in_valid beats ignored. After out_ready=1, the next frame starts from 0.
5. Async reset asserted between clock edges mid-frame after two beats of 100 -> outputs zero immediately, no result beat. A fresh frame of a single beat 7 with in_last -> out_acc=7, out_count=1.
6. Gapped valid: beats 10, (valid low 3 cycles), 20, 30 with last -> out_acc=60, out_count=3. Products presented with in_valid=0 do not affect the sum.
